// File: rtl/mul16_seq_pkg.sv
// Shared constants and state encoding for the mul16_seq shift-and-add multiplier.
// The optional overflow flag is enabled by defining MUL16_OVF_EN.
package mul16_seq_pkg;

    localparam int W     = 16;
    localparam int ITERS = 16;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul16_seq_step.sv
// Add16 ripple adder and one combinational shift-and-add iteration.
// With MUL16_OVF_EN defined, mul16_step also reports the adder carry-out.
module Add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);

    logic [15:0] w_c;

    assign w_c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_fa
            assign out[i] = a[i] ^ b[i] ^ w_c[i];
            if (i < 15) begin : g_c
                assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
            end
        end
    endgenerate

endmodule

module mul16_step
    import mul16_seq_pkg::*;
(
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_mcand,
    input  logic         i_bit,
`ifdef MUL16_OVF_EN
    output logic         o_ovf,
`endif
    output logic [W-1:0] o_acc
);

    logic [W-1:0] w_sum;

    Add16 u_add (
        .a   (i_acc),
        .b   (i_mcand),
        .out (w_sum)
    );

    assign o_acc = i_bit ? w_sum : i_acc;

`ifdef MUL16_OVF_EN
    // Carry-out rebuilt from the top bits, since Add16 exposes only the sum.
    assign o_ovf = i_bit &
                   ((i_acc[W-1] & i_mcand[W-1]) |
                    ((i_acc[W-1] ^ i_mcand[W-1]) & ~w_sum[W-1]));
`endif

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier, low 16 product bits, valid/ready in and out.
// Define MUL16_OVF_EN to get a sticky overflow flag on ovf; otherwise ovf is 0.
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         ovf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_mcand;
    logic [W-1:0]     r_mplier;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [W-1:0]     w_acc_nxt;

`ifdef MUL16_OVF_EN
    logic r_lost;
    logic r_ovf;
    logic w_step_ovf;
`endif

    mul16_step u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_bit   (r_mplier[0]),
`ifdef MUL16_OVF_EN
        .o_ovf   (w_step_ovf),
`endif
        .o_acc   (w_acc_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef MUL16_OVF_EN
            r_lost      <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
`ifdef MUL16_OVF_EN
                        r_lost   <= 1'b0;
                        r_ovf    <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
`ifdef MUL16_OVF_EN
                    // A set bit already shifted out of mcand means this add overflows.
                    r_lost   <= r_lost | r_mcand[W-1];
                    r_ovf    <= r_ovf | w_step_ovf | (r_mplier[0] & r_lost);
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out       = r_acc;

`ifdef MUL16_OVF_EN
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq: vector table plus handshake,
// back-pressure, mid-run reset and back-to-back sequences.
module tb_mul16_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        ovf;

    int n_checks = 0;
    int n_err    = 0;

`ifdef MUL16_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    mul16_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        logic        big;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          output logic [15:0] ro, output logic rv,
                          output int lat);
        @(negedge clock);
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        ro = out;
        rv = ovf;
        @(posedge clock);
        #1;
    endtask

    vec_t        tbl[8];
    logic [15:0] r_o;
    logic        r_v;
    int          lat;
    int          stray;
    int          c;
    int          t1;
    int          t2;
    logic [15:0] o1;
    logic [15:0] o2;

    initial begin
        tbl[0] = '{16'd3,     16'd5,     16'h000F, 1'b0};
        tbl[1] = '{16'hFFFF,  16'd1,     16'hFFFF, 1'b0};
        tbl[2] = '{16'd0,     16'h1234,  16'h0000, 1'b0};
        tbl[3] = '{16'd300,   16'd300,   16'h5F90, 1'b1};
        tbl[4] = '{16'd256,   16'd256,   16'h0000, 1'b1};
        tbl[5] = '{16'h00FF,  16'h0101,  16'hFFFF, 1'b0};
        tbl[6] = '{16'h8000,  16'd2,     16'h0000, 1'b1};
        tbl[7] = '{16'h1234,  16'h0056,  16'h1D78, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, r_o, r_v, lat);
            chk($sformatf("v%0d_lat", i), lat, 16);
            chk($sformatf("v%0d_out", i), r_o, tbl[i].prod);
            chk($sformatf("v%0d_ovf", i), r_v, tbl[i].big & OVF_ON);
            chk($sformatf("v%0d_idle", i), in_ready, 1);
            chk($sformatf("v%0d_vld_drop", i), out_valid, 0);
        end

        // Back-pressure: result held while out_ready is low.
        @(negedge clock);
        a         = 16'd7;
        b         = 16'd9;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("bp_lat", lat, 16);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            in_valid = 1'b1;
            a        = 16'd1;
            b        = 16'd1;
            @(posedge clock);
            #1;
            chk($sformatf("bp%0d_out", k), out, 16'h003F);
            chk($sformatf("bp%0d_vld", k), out_valid, 1);
            chk($sformatf("bp%0d_ovf", k), ovf, 0);
            chk($sformatf("bp%0d_rdy", k), in_ready, 0);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_after_rdy", in_ready, 1);
        chk("bp_after_vld", out_valid, 0);
        chk("bp_after_out", out, 16'h003F);

        // Reset after eight iterations discards the operation.
        @(negedge clock);
        a        = 16'h1234;
        b        = 16'h0056;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        chk("mid_busy", in_ready, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out", out, 0);
        chk("mr_ovf", ovf, 0);
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clock);
            #1;
            if (out_valid) stray++;
        end
        chk("mr_stray", stray, 0);

        // Back-to-back with in_valid held high.
        @(negedge clock);
        a         = 16'd2;
        b         = 16'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        c  = 0;
        t1 = -1;
        t2 = -1;
        o1 = '0;
        o2 = '0;
        while (t2 < 0 && c < 80) begin
            @(posedge clock);
            #1;
            c++;
            if (c == 1) begin
                a = 16'd4;
                b = 16'd5;
            end
            if (out_valid) begin
                if (t1 < 0) begin
                    t1 = c;
                    o1 = out;
                end else begin
                    t2 = c;
                    o2 = out;
                end
            end
        end
        chk("b2b_t1", t1, 17);
        chk("b2b_out1", o1, 16'h0006);
        chk("b2b_out2", o2, 16'h0014);
        chk("b2b_gap", t2 - t1, 18);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
